pong_round_ctrl: RTL and testbench

Round and frame sequencer for the pong game. It replaces the free-running DIV_CLK-paced state loop with one update sequence per video frame, issued on the frame-start pulse from the sync generator. It also owns serve countdown, scoring, speed ramp, pause and game-over. It drives one-cycle strobes into the ball/paddle datapath and exports the scores to the on-screen digit renderers.

---
 rtl/pong_pkg.sv | 45 ++++
 rtl/pong_frame_timer.sv | 37 +++
 rtl/pong_round_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_pong_round_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg
//   Shared definitions for the pong round/frame sequencer and its helpers:
//   state encoding, update-sequence step codes, field widths, winner codes
//   and the coordinates the datapath parks the ball at between rallies.
package pong_pkg;

  localparam int SPEED_W = 4;
  localparam int SCORE_W = 4;
  localparam int HIT_W   = 4;
  localparam int TIMER_W = 8;
  localparam int SEQ_W   = 3;

  // Where the datapath holds the ball while ball_reset is high.
  localparam logic [9:0] BALL_X_RESET = 10'd315;
  localparam logic [9:0] BALL_Y_RESET = 10'd235;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_PAUSED   = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_t;

  // Per-frame update sequence: 0 means no sequence in flight, 1..5 are c0..c4.
  localparam logic [SEQ_W-1:0] SEQ_IDLE    = 3'd0;
  localparam logic [SEQ_W-1:0] SEQ_PADDLE  = 3'd1;
  localparam logic [SEQ_W-1:0] SEQ_BALL    = 3'd2;
  localparam logic [SEQ_W-1:0] SEQ_CENTER  = 3'd3;
  localparam logic [SEQ_W-1:0] SEQ_COLLIDE = 3'd4;
  localparam logic [SEQ_W-1:0] SEQ_SAMPLE  = 3'd5;

  // One speed step up, clamped at the ceiling.
  function automatic logic [SPEED_W-1:0] speed_step(
    input logic [SPEED_W-1:0] cur,
    input logic [SPEED_W-1:0] ceiling
  );
    return (cur >= ceiling) ? ceiling : cur + SPEED_W'(1);
  endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// pong_frame_timer
//   Frame-paced down-counter used for the serve countdown.
//   Ports:
//     board_clk, reset  clock and asynchronous active-high reset
//     load, load_value  synchronous load (wins over decrement)
//     frame_start       decrement request, one per video frame
//     enable            low freezes the count (pause)
//     zero              high while the count is 0
module pong_frame_timer
  import pong_pkg::*;
#(
  parameter int WIDTH = TIMER_W
) (
  input  logic             board_clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             frame_start,
  input  logic             enable,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Stops at zero so a late frame_start cannot wrap the countdown.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (enable && frame_start && !zero)
      count <= count - WIDTH'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pong_round_ctrl.sv
// pong_round_ctrl
//   Round and frame sequencer for pong. Runs one five-step update sequence
//   per video frame, and owns serve countdown, scoring, speed ramp, pause
//   and game-over.
//   Ports:
//     board_clk, reset            clock, asynchronous active-high reset
//     frame_start                 one-cycle pulse at start of vertical blank
//     start_btn                   synchronised level, rising edge starts a game
//     pause                       level
//     goal_left, goal_right       datapath goal levels, used in sample step
//     paddle_hit                  datapath hit level, used in sample step
//     upd_paddle, upd_ball,
//     upd_center, chk_collide     one-cycle registered sequence strobes
//     ball_reset                  datapath parks the ball at centre while high
//     serve_dir                   X direction of next serve, 1 = rightward
//     ball_speed                  current ball speed
//     p1_score, p2_score          scores
//     winner                      00 none, 01 P1, 10 P2
//     state_out                   encoded state for LEDs
module pong_round_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE        = 9,
  parameter int SERVE_FRAMES     = 60,
  parameter int HITS_PER_SPEEDUP = 4,
  parameter int MAX_SPEED        = 8
) (
  input  logic               board_clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               start_btn,
  input  logic               pause,
  input  logic               goal_left,
  input  logic               goal_right,
  input  logic               paddle_hit,
  output logic               upd_paddle,
  output logic               upd_ball,
  output logic               upd_center,
  output logic               chk_collide,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SPEED_W-1:0] ball_speed,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         winner,
  output logic [2:0]         state_out
);

  localparam logic [SCORE_W-1:0] WIN_SCORE_L  = SCORE_W'(WIN_SCORE);
  localparam logic [TIMER_W-1:0] SERVE_LOAD   = TIMER_W'(SERVE_FRAMES);
  localparam logic [HIT_W-1:0]   HITS_LIMIT   = HIT_W'(HITS_PER_SPEEDUP);
  localparam logic [SPEED_W-1:0] SPEED_CEIL   = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W-1:0] SPEED_SERVE  = SPEED_W'(1);

  state_t             state, state_next;
  state_t             origin, origin_next;
  logic [SEQ_W-1:0]   seq, seq_next;
  logic [HIT_W-1:0]   hits, hits_next;
  logic [SCORE_W-1:0] p1_next, p2_next;
  logic [SPEED_W-1:0] speed_next;
  logic [1:0]         winner_next;
  logic               dir_next;
  logic [HIT_W-1:0]   hit_inc;
  logic               timer_load;
  logic               timer_zero;
  logic               serve_active;
  logic               start_prev;
  logic               start_pulse;

  // Start edge detector; the registered pulse adds one cycle of latency.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      start_prev  <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      start_prev  <= start_btn;
      start_pulse <= start_btn & ~start_prev;
    end
  end

  assign serve_active = (state == ST_SERVE);

  // The serve countdown only runs in SERVE, so PAUSED leaves it frozen.
  pong_frame_timer #(
    .WIDTH (TIMER_W)
  ) u_serve_timer (
    .board_clk   (board_clk),
    .reset       (reset),
    .load        (timer_load),
    .load_value  (SERVE_LOAD),
    .frame_start (frame_start),
    .enable      (serve_active),
    .zero        (timer_zero)
  );

  // State register.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      origin <= ST_PLAY;
    end else begin
      state  <= state_next;
      origin <= origin_next;
    end
  end

  // Next-state and round bookkeeping. The serve timer is reloaded only on
  // a fresh entry into SERVE, never when returning from PAUSED.
  always_comb begin
    state_next  = state;
    origin_next = origin;
    seq_next    = seq;
    hits_next   = hits;
    p1_next     = p1_score;
    p2_next     = p2_score;
    speed_next  = ball_speed;
    winner_next = winner;
    dir_next    = serve_dir;
    timer_load  = 1'b0;
    hit_inc     = hits + HIT_W'(1);

    case (state)
      ST_IDLE, ST_GAMEOVER: begin
        if (start_pulse) begin
          p1_next     = '0;
          p2_next     = '0;
          winner_next = WINNER_NONE;
          dir_next    = 1'b1;
          speed_next  = SPEED_SERVE;
          hits_next   = '0;
          seq_next    = SEQ_IDLE;
          timer_load  = 1'b1;
          state_next  = ST_SERVE;
        end
      end

      ST_SERVE: begin
        if (pause) begin
          origin_next = ST_SERVE;
          state_next  = ST_PAUSED;
        end else if (timer_zero) begin
          state_next = ST_PLAY;
        end
      end

      // Pause is only looked at on a frame boundary, so a running
      // sequence always reaches its sample step.
      ST_PLAY: begin
        if (seq == SEQ_IDLE) begin
          if (frame_start) begin
            if (pause) begin
              origin_next = ST_PLAY;
              state_next  = ST_PAUSED;
            end else begin
              seq_next = SEQ_PADDLE;
            end
          end
        end else if (seq == SEQ_SAMPLE) begin
          seq_next = SEQ_IDLE;
          if (goal_left || goal_right) begin
            speed_next = SPEED_SERVE;
            hits_next  = '0;
            state_next = ST_SERVE;
            timer_load = 1'b1;
            if (goal_left && !goal_right) begin
              p2_next  = p2_score + SCORE_W'(1);
              dir_next = 1'b0;
              if (p2_next == WIN_SCORE_L) begin
                winner_next = WINNER_P2;
                state_next  = ST_GAMEOVER;
                timer_load  = 1'b0;
              end
            end else if (goal_right && !goal_left) begin
              p1_next  = p1_score + SCORE_W'(1);
              dir_next = 1'b1;
              if (p1_next == WIN_SCORE_L) begin
                winner_next = WINNER_P1;
                state_next  = ST_GAMEOVER;
                timer_load  = 1'b0;
              end
            end
          end else if (paddle_hit) begin
            if (hit_inc == HITS_LIMIT) begin
              hits_next  = '0;
              speed_next = speed_step(ball_speed, SPEED_CEIL);
            end else begin
              hits_next = hit_inc;
            end
          end
        end else begin
          seq_next = seq + SEQ_W'(1);
        end
      end

      ST_PAUSED: begin
        if (!pause)
          state_next = origin;
      end

      default: begin
        seq_next   = SEQ_IDLE;
        state_next = ST_IDLE;
      end
    endcase
  end

  // Round registers and strobes. Strobes are decoded from the next sequence
  // step so each one is a clean registered one-cycle pulse, and an async
  // reset kills whatever remains of a sequence.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      seq         <= SEQ_IDLE;
      hits        <= '0;
      p1_score    <= '0;
      p2_score    <= '0;
      ball_speed  <= SPEED_SERVE;
      winner      <= WINNER_NONE;
      serve_dir   <= 1'b1;
      ball_reset  <= 1'b1;
      upd_paddle  <= 1'b0;
      upd_ball    <= 1'b0;
      upd_center  <= 1'b0;
      chk_collide <= 1'b0;
    end else begin
      seq         <= seq_next;
      hits        <= hits_next;
      p1_score    <= p1_next;
      p2_score    <= p2_next;
      ball_speed  <= speed_next;
      winner      <= winner_next;
      serve_dir   <= dir_next;
      ball_reset  <= !((state_next == ST_PLAY) ||
                       ((state_next == ST_PAUSED) && (origin_next == ST_PLAY)));
      upd_paddle  <= (seq_next == SEQ_PADDLE);
      upd_ball    <= (seq_next == SEQ_BALL);
      upd_center  <= (seq_next == SEQ_CENTER);
      chk_collide <= (seq_next == SEQ_COLLIDE);
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_pong_round_ctrl.sv
// tb_pong_round_ctrl
//   Scoreboard bench for pong_round_ctrl. Two instances share all stimulus:
//   dut_a uses MAX_SPEED=8, dut_b uses MAX_SPEED=2; both use SERVE_FRAMES=3.
//   Stimulus pushes expected strobe patterns and status snapshots into
//   queues; a monitor on the falling edge pops and compares them.
module tb_pong_round_ctrl;

  typedef struct {
    string name;
    int    st;
    int    p1;
    int    p2;
    int    win;
    int    dir;
    int    brst;
    int    spd_a;
    int    spd_b;
  } snap_t;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_PAUSED = 3, S_OVER = 4;

  logic board_clk = 1'b0;
  logic reset, frame_start, start_btn, pause, goal_left, goal_right, paddle_hit;

  logic       a_paddle, a_ball, a_center, a_collide, a_brst, a_dir;
  logic [3:0] a_speed, a_p1, a_p2;
  logic [1:0] a_win;
  logic [2:0] a_state;
  logic       b_paddle, b_ball, b_center, b_collide, b_brst, b_dir;
  logic [3:0] b_speed, b_p1, b_p2;
  logic [1:0] b_win;
  logic [2:0] b_state;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] strobe_q[$];
  snap_t      snap_q[$];

  always #5 board_clk = ~board_clk;

  pong_round_ctrl #(
    .WIN_SCORE(9), .SERVE_FRAMES(3), .HITS_PER_SPEEDUP(4), .MAX_SPEED(8)
  ) dut_a (
    .board_clk(board_clk), .reset(reset), .frame_start(frame_start),
    .start_btn(start_btn), .pause(pause), .goal_left(goal_left),
    .goal_right(goal_right), .paddle_hit(paddle_hit),
    .upd_paddle(a_paddle), .upd_ball(a_ball), .upd_center(a_center),
    .chk_collide(a_collide), .ball_reset(a_brst), .serve_dir(a_dir),
    .ball_speed(a_speed), .p1_score(a_p1), .p2_score(a_p2),
    .winner(a_win), .state_out(a_state)
  );

  pong_round_ctrl #(
    .WIN_SCORE(9), .SERVE_FRAMES(3), .HITS_PER_SPEEDUP(4), .MAX_SPEED(2)
  ) dut_b (
    .board_clk(board_clk), .reset(reset), .frame_start(frame_start),
    .start_btn(start_btn), .pause(pause), .goal_left(goal_left),
    .goal_right(goal_right), .paddle_hit(paddle_hit),
    .upd_paddle(b_paddle), .upd_ball(b_ball), .upd_center(b_center),
    .chk_collide(b_collide), .ball_reset(b_brst), .serve_dir(b_dir),
    .ball_speed(b_speed), .p1_score(b_p1), .p2_score(b_p2),
    .winner(b_win), .state_out(b_state)
  );

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Monitor: any strobe activity consumes one expected pattern; queued
  // status snapshots are compared on the same falling edge.
  always @(negedge board_clk) begin
    logic [3:0] sa, sb, e;
    snap_t      s;
    sa = {a_paddle, a_ball, a_center, a_collide};
    sb = {b_paddle, b_ball, b_center, b_collide};
    if (sa != 4'b0 || sb != 4'b0) begin
      if (strobe_q.size() == 0) begin
        chk("unexpected strobe", int'({sa, sb}), 0);
      end else begin
        e = strobe_q.pop_front();
        chk("strobe dut_a", int'(sa), int'(e));
        chk("strobe dut_b", int'(sb), int'(e));
      end
    end
    while (snap_q.size() > 0) begin
      s = snap_q.pop_front();
      chk({s.name, " state_a"}, int'(a_state), s.st);
      chk({s.name, " state_b"}, int'(b_state), s.st);
      chk({s.name, " p1_a"}, int'(a_p1), s.p1);
      chk({s.name, " p1_b"}, int'(b_p1), s.p1);
      chk({s.name, " p2_a"}, int'(a_p2), s.p2);
      chk({s.name, " p2_b"}, int'(b_p2), s.p2);
      chk({s.name, " winner_a"}, int'(a_win), s.win);
      chk({s.name, " winner_b"}, int'(b_win), s.win);
      chk({s.name, " serve_dir_a"}, int'(a_dir), s.dir);
      chk({s.name, " serve_dir_b"}, int'(b_dir), s.dir);
      chk({s.name, " ball_reset_a"}, int'(a_brst), s.brst);
      chk({s.name, " ball_reset_b"}, int'(b_brst), s.brst);
      chk({s.name, " speed_a"}, int'(a_speed), s.spd_a);
      chk({s.name, " speed_b"}, int'(b_speed), s.spd_b);
    end
  end

  task automatic checkOutput(input string nm, input int st, input int p1,
                             input int p2, input int win, input int dir,
                             input int brst, input int spd_a, input int spd_b);
    snap_t s;
    s.name = nm; s.st = st; s.p1 = p1; s.p2 = p2; s.win = win;
    s.dir = dir; s.brst = brst; s.spd_a = spd_a; s.spd_b = spd_b;
    snap_q.push_back(s);
  endtask

  // One frame_start pulse, then enough cycles for a full sequence and its
  // sample-step update. Strobes c0..c3 are expected when a sequence should run.
  task automatic applyStimulus(input bit expect_seq);
    if (expect_seq) begin
      strobe_q.push_back(4'b1000);
      strobe_q.push_back(4'b0100);
      strobe_q.push_back(4'b0010);
      strobe_q.push_back(4'b0001);
    end
    @(posedge board_clk); #1 frame_start = 1'b1;
    @(posedge board_clk); #1 frame_start = 1'b0;
    repeat (6) @(posedge board_clk);
    #1;
  endtask

  task automatic serve_to_play(input int p1, input int p2, input int dir);
    repeat (3) applyStimulus(1'b0);
    checkOutput("serve to play", S_PLAY, p1, p2, 0, dir, 0, 1, 1);
  endtask

  task automatic restart_game();
    @(posedge board_clk); #1 start_btn = 1'b1;
    repeat (2) @(posedge board_clk);
    #1 checkOutput("restart", S_SERVE, 0, 0, 0, 1, 1, 1, 1);
    start_btn = 1'b0;
  endtask

  initial begin
    int spd;
    reset = 1'b1; frame_start = 1'b0; start_btn = 1'b0; pause = 1'b0;
    goal_left = 1'b0; goal_right = 1'b0; paddle_hit = 1'b0;

    // Power-on values while reset is held.
    repeat (2) @(posedge board_clk);
    #1 checkOutput("power-on", S_IDLE, 0, 0, 0, 1, 1, 1, 1);
    @(posedge board_clk); #1 reset = 1'b0;

    // Start edge: still IDLE one edge later, SERVE two edges later.
    @(posedge board_clk); #1 start_btn = 1'b1;
    @(posedge board_clk); #1 checkOutput("start+1", S_IDLE, 0, 0, 0, 1, 1, 1, 1);
    @(posedge board_clk); #1 checkOutput("start+2", S_SERVE, 0, 0, 0, 1, 1, 1, 1);
    start_btn = 1'b0;

    // Two serve frames are not enough; the third releases the ball.
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("serve 2 frames", S_SERVE, 0, 0, 0, 1, 1, 1, 1);
    applyStimulus(1'b0);
    checkOutput("serve 3 frames", S_PLAY, 0, 0, 0, 1, 0, 1, 1);

    // Plain frame, start_btn ignored in PLAY.
    start_btn = 1'b1;
    applyStimulus(1'b1);
    start_btn = 1'b0;
    checkOutput("first play frame", S_PLAY, 0, 0, 0, 1, 0, 1, 1);

    // Speed ramp: a step every 4 hits; dut_b clamps at 2.
    paddle_hit = 1'b1;
    for (int f = 1; f <= 12; f++) begin
      applyStimulus(1'b1);
      spd = 1 + f / 4;
      checkOutput($sformatf("ramp frame %0d", f), S_PLAY, 0, 0, 0, 1, 0,
                  spd, (spd > 2) ? 2 : spd);
    end
    paddle_hit = 1'b0;

    // Both goals at once: no score, direction kept, re-serve at speed 1.
    goal_left = 1'b1; goal_right = 1'b1;
    applyStimulus(1'b1);
    goal_left = 1'b0; goal_right = 1'b0;
    checkOutput("double goal", S_SERVE, 0, 0, 0, 1, 1, 1, 1);
    serve_to_play(0, 0, 1);

    // Pause raised during c1: the sequence finishes, next frame pauses.
    strobe_q.push_back(4'b1000);
    strobe_q.push_back(4'b0100);
    strobe_q.push_back(4'b0010);
    strobe_q.push_back(4'b0001);
    @(posedge board_clk); #1 frame_start = 1'b1;
    @(posedge board_clk); #1 frame_start = 1'b0;
    @(posedge board_clk); #1 pause = 1'b1;
    repeat (5) @(posedge board_clk);
    #1 checkOutput("pause mid-seq", S_PLAY, 0, 0, 0, 1, 0, 1, 1);
    applyStimulus(1'b0);
    checkOutput("paused", S_PAUSED, 0, 0, 0, 1, 0, 1, 1);
    repeat (5) applyStimulus(1'b0);
    checkOutput("paused 5 frames", S_PAUSED, 0, 0, 0, 1, 0, 1, 1);
    pause = 1'b0;
    @(posedge board_clk); #1 checkOutput("unpause", S_PLAY, 0, 0, 0, 1, 0, 1, 1);
    applyStimulus(1'b1);
    checkOutput("resumed frame", S_PLAY, 0, 0, 0, 1, 0, 1, 1);

    // Left goal scores for P2 and serves leftward.
    goal_left = 1'b1;
    applyStimulus(1'b1);
    goal_left = 1'b0;
    checkOutput("goal left", S_SERVE, 0, 1, 0, 0, 1, 1, 1);
    serve_to_play(0, 1, 0);

    // Nine right goals: P1 reaches 9 and wins.
    for (int i = 1; i <= 9; i++) begin
      goal_right = 1'b1;
      applyStimulus(1'b1);
      goal_right = 1'b0;
      if (i < 9) begin
        checkOutput($sformatf("goal right %0d", i), S_SERVE, i, 1, 0, 1, 1, 1, 1);
        serve_to_play(i, 1, 1);
      end else begin
        checkOutput("game over", S_OVER, 9, 1, 1, 1, 1, 1, 1);
      end
    end
    applyStimulus(1'b0);
    checkOutput("game over frame", S_OVER, 9, 1, 1, 1, 1, 1, 1);

    // New game from GAMEOVER, one goal, then reset while c1/c2.
    restart_game();
    serve_to_play(0, 0, 1);
    goal_right = 1'b1;
    applyStimulus(1'b1);
    goal_right = 1'b0;
    checkOutput("new game goal", S_SERVE, 1, 0, 0, 1, 1, 1, 1);
    serve_to_play(1, 0, 1);

    strobe_q.push_back(4'b1000);
    strobe_q.push_back(4'b0100);
    @(posedge board_clk); #1 frame_start = 1'b1;
    @(posedge board_clk); #1 frame_start = 1'b0;
    @(posedge board_clk); #6 reset = 1'b1;
    checkOutput("reset mid-seq", S_IDLE, 0, 0, 0, 1, 1, 1, 1);
    repeat (3) @(posedge board_clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge board_clk);
    #1 chk("strobe queue drained", strobe_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
